// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic MIPS pipeline-stage register (F/D, D/E, E/M, M/W).
// Carries an opaque payload, the PC, the branch-delay-slot flag and a valid
// bit. It supports bubble insertion that keeps the PC/BD fields, exception
// redirection to a fixed handler PC, and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int              DATA_W   = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [PC_W-1:0] EXC_PC   = 32'h0000_4180,
  parameter int              CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              req,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_bd,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_bd,
  output logic              out_loaded,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              valid_d,  valid_q;
  logic [DATA_W-1:0] data_d,   data_q;
  logic [PC_W-1:0]   pc_d,     pc_q;
  logic              bd_d,     bd_q;
  logic              loaded_d, loaded_q;
  logic [CNT_W-1:0]  cnt_d,    cnt_q;

  // Next-state selection. Priority: req > stall > flush > load. Reset is
  // applied in the register block so it overrides everything.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    pc_d     = pc_q;
    bd_d     = bd_q;
    loaded_d = 1'b0;
    cnt_d    = cnt_q;
    if (req) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = EXC_PC;
      bd_d    = 1'b0;
    end else if (stall) begin
      // Hold everything; out_loaded drops because nothing new was captured.
    end else if (flush) begin
      // Bubble keeps PC/BD so an exception on it reports the right PC.
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = in_pc;
      bd_d    = in_bd;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      // Payload is captured even for an invalid slot; valid qualifies it.
      valid_d  = in_valid;
      data_d   = in_data;
      pc_d     = in_pc;
      bd_d     = in_bd;
      loaded_d = in_valid;
    end
  end

  // Stage registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      pc_q     <= RESET_PC;
      bd_q     <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      pc_q     <= pc_d;
      bd_q     <= bd_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_pc     = pc_q;
  assign out_bd     = bd_q;
  assign out_loaded = loaded_q;
  assign bubble_cnt = cnt_q;

endmodule
